glyph_blitter: RTL and testbench
================================

// Module: glyph_blitter
// PURPOSE
//  Sequences the 7-bit-ASCII -> 8x16 glyph-bitmap decoder (char_decoder) to draw one text cell into the VGA pixel plotter.
//  Accepts one character request at a time, drives the decoder, and latches its 128-bit bitmap.
//  Then emits one pixel write per bitmap bit, under a valid/ready handshake, toward the frame-buffer adapter.
//  Sits between the text/cursor logic and the vga adapter.
// PARAMETERS
//  COLOUR_W     3      pixel colour width
//  X_W          8      pixel x width (160-px screen)
//  Y_W          7      pixel y width (120-px screen)
//  TEXT_COLS    20     text columns; a cell is 8 px wide
//  TEXT_ROWS    7      text rows; a cell is 16 px tall
//  FG_COLOUR    3'b111 colour for set glyph bits
//  BG_COLOUR    3'b000 colour for clear glyph bits
//  TRANSPARENT  0      1 = clear bits are skipped (no write); 0 = written as BG_COLOUR
// PORTS
//  clk          in   1         system clock, rising edge
//  resetn       in   1         async active-low reset
//  start        in   1         request; accepted only when ready=1
//  char_code    in   7         ASCII code, sampled on accept
//  cell_col     in   5         text column, sampled on accept
//  cell_row     in   3         text row, sampled on accept
//  ready        out  1         high only in IDLE
//  done         out  1         1-cycle pulse at end of every accepted request
//  err          out  1         1-cycle pulse with done when the cell is out of range
//  glyph_code   out  7         to char_decoder IN; registered
//  glyph_bits   in   128       from char_decoder OUT (combinational)
//  plot         out  1         pixel write valid
//  pix_ready    in   1         pixel sink ready; a write transfers when plot & pix_ready
//  x            out  X_W       pixel x
//  y            out  Y_W       pixel y
//  colour       out  COLOUR_W  pixel colour
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ready=1, done=0, err=0, plot=0.
//  Reset also clears glyph_code, x, y, colour and the pixel index to 0. No done pulse is issued for an aborted request.
//  FSM IDLE -> FETCH -> DRAW -> DONE -> IDLE. All outputs are registered or decoded from state only.
//  IDLE: on start, register char_code (onto glyph_code), cell_col and cell_row, then go to FETCH. If start=0, stay.
//  start while ready=0 is ignored, not queued.
//  FETCH (1 cycle): glyph_code is stable. The FSM latches glyph_bits into an internal 128-bit register and clears pixel index n.
//  FETCH -> DONE with err=1 and no pixel writes if cell_col>=TEXT_COLS or cell_row>=TEXT_ROWS. Otherwise FETCH -> DRAW.
//  DRAW: n = 0..127; py=n[6:3], px=n[2:0]; bit b = latched[127-n] (MSB = top-left, rows top-down, left-to-right).
//  Pixel coordinates: x = cell_col*8 + px, y = cell_row*16 + py.
//  colour = b ? FG_COLOUR : BG_COLOUR. x/y/colour are truncated to port width.
//  Writing pixel n: plot=1 with x/y/colour held stable until pix_ready=1. n advances on that transfer.
//  Skipping pixel n (TRANSPARENT=1 and b=0): plot=0, and n advances in 1 cycle regardless of pix_ready.
//  After pixel 127 is transferred or skipped, go to DONE.
//  DONE (1 cycle): done=1, err as computed, then IDLE. ready returns 1 the following cycle.
//  Latency with pix_ready=1 and TRANSPARENT=0: accept at edge k. FETCH covers cycle k+1. Plots cover cycles k+2..k+129.
//  The done pulse is in cycle k+130. Each cycle of pix_ready=0 during a write adds one cycle.
//  glyph_code holds its last value between requests. plot is never asserted outside DRAW.
// TESTING
//  1. 'I'(73) at col0,row0, pix_ready=1 -> 128 plots in raster order.
//     Row y=0 is all BG; (x=2..4,y=1) FG; (x=3,y=2) FG. done exactly 130 cycles after accept, err=0.
//  2. '.'(46) at col2,row1 -> FG only at (19,23) and (19,24). All other 126 writes are BG, x in 16..23, y in 16..31.
//  3. 'A'(65), pix_ready low 3 cycles at n=5 -> x/y/colour held across the stall.
//     Exactly 128 transfers, no duplicate or missing coords, done at cycle k+133.
//  4. TRANSPARENT=1, space(32) -> zero plots, done at k+130. TRANSPARENT=1 'I' -> plots only at FG coordinates.
//  5. col=20,row=0 -> no plot, done=err=1 at k+2, ready=1 at k+3. start pulsed during DRAW is ignored.
//  6. resetn low at n=40 -> plot=0 and ready=1 immediately, no done. A following '0'(48) request completes normally.

Source files
------------

// File: rtl/glyph_blitter_if.sv
// rtl/glyph_blitter_if.sv - request and pixel-write bus between text logic, glyph_blitter and the vga adapter
// master = the blitter; slave = the surrounding text/cursor logic and pixel sink.
interface glyph_blitter_if #(
   parameter int COLOUR_W = 3,
   parameter int X_W      = 8,
   parameter int Y_W      = 7
);
   logic                start;
   logic [6:0]          char_code;
   logic [4:0]          cell_col;
   logic [2:0]          cell_row;
   logic                ready;
   logic                done;
   logic                err;
   logic                plot;
   logic                pix_ready;
   logic [X_W-1:0]      x;
   logic [Y_W-1:0]      y;
   logic [COLOUR_W-1:0] colour;

   modport master (
      input  start, char_code, cell_col, cell_row, pix_ready,
      output ready, done, err, plot, x, y, colour
   );

   modport slave (
      output start, char_code, cell_col, cell_row, pix_ready,
      input  ready, done, err, plot, x, y, colour
   );
endinterface

// File: rtl/glyph_blitter.sv
// rtl/glyph_blitter.sv - draws one 8x16 glyph cell as a stream of pixel writes
// Sequences char_decoder: registers the code, latches its bitmap, then walks the 128 bits in raster order.
module glyph_blitter #(
   parameter int                   COLOUR_W    = 3,
   parameter int                   X_W         = 8,
   parameter int                   Y_W         = 7,
   parameter int                   TEXT_COLS   = 20,
   parameter int                   TEXT_ROWS   = 7,
   parameter logic [COLOUR_W-1:0]  FG_COLOUR   = 3'b111,
   parameter logic [COLOUR_W-1:0]  BG_COLOUR   = 3'b000,
   parameter bit                   TRANSPARENT = 1'b0
) (
   input  logic                clk,
   input  logic                resetn,
   glyph_blitter_if.master     bus,
   output logic [6:0]          glyph_code,
   input  logic [127:0]        glyph_bits
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAW, S_DONE} state_t;

   state_t              r_state;
   logic [127:0]        r_bits;
   logic [6:0]          r_n;
   logic [6:0]          r_glyph_code;
   logic [4:0]          r_col;
   logic [2:0]          r_row;
   logic                r_plot;
   logic                r_done;
   logic                r_err;
   logic [X_W-1:0]      r_x;
   logic [Y_W-1:0]      r_y;
   logic [COLOUR_W-1:0] r_colour;

   logic [6:0]          w_n_next;
   logic                w_b_next;
   logic                w_in_range;
   logic                w_advance;

   // A cell is 8 px wide and 16 px tall, so col*8+px and row*16+py are plain concatenations.
   function automatic logic [X_W-1:0] pix_x(input logic [4:0] col, input logic [2:0] px);
      logic [15:0] s;
      s = {8'd0, col, px};
      return s[X_W-1:0];
   endfunction

   function automatic logic [Y_W-1:0] pix_y(input logic [2:0] row, input logic [3:0] py);
      logic [15:0] s;
      s = {9'd0, row, py};
      return s[Y_W-1:0];
   endfunction

   function automatic logic shown(input logic b);
      return (TRANSPARENT == 1'b0) || b;
   endfunction

   assign w_n_next   = r_n + 7'd1;
   assign w_b_next   = r_bits[~w_n_next];
   assign w_in_range = (int'(r_col) < TEXT_COLS) && (int'(r_row) < TEXT_ROWS);
   // A skipped pixel (plot low) advances unconditionally; a written one waits for the sink.
   assign w_advance  = r_plot ? bus.pix_ready : 1'b1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_bits       <= '0;
         r_n          <= '0;
         r_glyph_code <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_plot       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_x          <= '0;
         r_y          <= '0;
         r_colour     <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_glyph_code <= bus.char_code;
                  r_col        <= bus.cell_col;
                  r_row        <= bus.cell_row;
                  r_state      <= S_FETCH;
               end
            end
            S_FETCH: begin
               r_bits <= glyph_bits;
               r_n    <= '0;
               if (!w_in_range) begin
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_x      <= pix_x(r_col, 3'd0);
                  r_y      <= pix_y(r_row, 4'd0);
                  r_colour <= glyph_bits[127] ? FG_COLOUR : BG_COLOUR;
                  r_plot   <= shown(glyph_bits[127]);
                  r_state  <= S_DRAW;
               end
            end
            S_DRAW: begin
               if (w_advance) begin
                  if (r_n == 7'd127) begin
                     r_plot  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_n      <= w_n_next;
                     r_x      <= pix_x(r_col, w_n_next[2:0]);
                     r_y      <= pix_y(r_row, w_n_next[6:3]);
                     r_colour <= w_b_next ? FG_COLOUR : BG_COLOUR;
                     r_plot   <= shown(w_b_next);
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ready  = (r_state == S_IDLE);
   assign bus.done   = r_done;
   assign bus.err    = r_err;
   assign bus.plot   = r_plot;
   assign bus.x      = r_x;
   assign bus.y      = r_y;
   assign bus.colour = r_colour;
   assign glyph_code = r_glyph_code;

endmodule

// File: tb/tb_glyph_blitter.sv
// tb/tb_glyph_blitter.sv - directed and randomized bench for glyph_blitter against a raster-walk model
// Instance d0 writes background pixels; instance d1 is the transparent variant.
module tb_glyph_blitter;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic       sel = 1'b0;
   logic       t_start = 1'b0;
   logic [6:0] t_code = '0;
   logic [4:0] t_col = '0;
   logic [2:0] t_row = '0;
   logic       t_pix_ready = 1'b1;

   logic [6:0]   gc0, gc1;
   logic [127:0] gb0, gb1;

   glyph_blitter_if #(.COLOUR_W(3), .X_W(8), .Y_W(7)) bus0 ();
   glyph_blitter_if #(.COLOUR_W(3), .X_W(8), .Y_W(7)) bus1 ();

   // Stand-in font: 'I', '.', space are hand drawn, every other code gets a hashed pattern.
   function automatic logic [127:0] font(input logic [6:0] c);
      logic [127:0] g;
      logic [7:0]   r;
      logic [7:0]   t;
      g = '0;
      t = {1'b0, c};
      for (int i = 0; i < 16; i++) begin
         case (c)
            7'd32:   r = 8'h00;
            7'd73:   r = (i == 1 || i == 13) ? 8'h38 : ((i >= 2 && i <= 12) ? 8'h10 : 8'h00);
            7'd46:   r = (i == 7 || i == 8) ? 8'h10 : 8'h00;
            default: r = (t * 8'd37) ^ (8'(i) * 8'd73) ^ 8'h5a;
         endcase
         g[127 - 8 * i -: 8] = r;
      end
      return g;
   endfunction

   assign gb0 = font(gc0);
   assign gb1 = font(gc1);

   assign bus0.start     = t_start && !sel;
   assign bus1.start     = t_start && sel;
   assign bus0.char_code = t_code;
   assign bus1.char_code = t_code;
   assign bus0.cell_col  = t_col;
   assign bus1.cell_col  = t_col;
   assign bus0.cell_row  = t_row;
   assign bus1.cell_row  = t_row;
   assign bus0.pix_ready = t_pix_ready;
   assign bus1.pix_ready = t_pix_ready;

   glyph_blitter #(.TRANSPARENT(1'b0)) d0 (
      .clk(clk), .resetn(resetn), .bus(bus0.master), .glyph_code(gc0), .glyph_bits(gb0)
   );
   glyph_blitter #(.TRANSPARENT(1'b1)) d1 (
      .clk(clk), .resetn(resetn), .bus(bus1.master), .glyph_code(gc1), .glyph_bits(gb1)
   );

   logic       s_ready, s_done, s_err, s_plot;
   logic [7:0] s_x;
   logic [6:0] s_y;
   logic [2:0] s_c;
   logic [6:0] s_gc;
   assign s_ready = sel ? bus1.ready  : bus0.ready;
   assign s_done  = sel ? bus1.done   : bus0.done;
   assign s_err   = sel ? bus1.err    : bus0.err;
   assign s_plot  = sel ? bus1.plot   : bus0.plot;
   assign s_x     = sel ? bus1.x      : bus0.x;
   assign s_y     = sel ? bus1.y      : bus0.y;
   assign s_c     = sel ? bus1.colour : bus0.colour;
   assign s_gc    = sel ? gc1 : gc0;

   logic [7:0] q_x[$];
   logic [6:0] q_y[$];
   logic [2:0] q_c[$];
   logic [7:0] e_x[$];
   logic [6:0] e_y[$];
   logic [2:0] e_c[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input bit transp, input logic [6:0] code, input int col, input int row);
      logic [127:0] g;
      logic         b;
      g = font(code);
      e_x.delete(); e_y.delete(); e_c.delete();
      if (col < 20 && row < 7) begin
         for (int n = 0; n < 128; n++) begin
            b = g[127 - n];
            if (!transp || b) begin
               e_x.push_back(8'(col * 8 + n % 8));
               e_y.push_back(7'(row * 16 + n / 8));
               e_c.push_back(b ? 3'b111 : 3'b000);
            end
         end
      end
   endtask

   task automatic compare_pixels(input string tag);
      int m;
      chk({tag, "_count"}, 32'(q_x.size()), 32'(e_x.size()));
      m = (q_x.size() < e_x.size()) ? q_x.size() : e_x.size();
      for (int i = 0; i < m; i++)
         chk({tag, "_pix"}, 32'({q_x[i], q_y[i], q_c[i]}), 32'({e_x[i], e_y[i], e_c[i]}));
   endtask

   task automatic run_req(input bit s, input logic [6:0] code, input logic [4:0] col,
                          input logic [2:0] row, input int stall_at, input int stall_len,
                          input int pulse_at, output int done_at, output logic err_seen);
      int         stalled;
      int         guard;
      logic       pp, ppr;
      logic [17:0] pv;
      sel = s;
      q_x.delete(); q_y.delete(); q_c.delete();
      done_at = -1;
      err_seen = 1'b0;
      guard = 0;
      while (!s_ready && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      t_code = code; t_col = col; t_row = row;
      t_start = 1'b1;
      t_pix_ready = 1'b1;
      @(posedge clk); #1;
      t_start = 1'b0;
      stalled = 0;
      pp = 1'b0;
      ppr = 1'b1;
      pv = '0;
      for (int i = 1; i < 400; i++) begin
         t_start = (i == pulse_at);
         if (pp && !ppr && s_plot)
            chk("stall_hold", 32'({s_x, s_y, s_c}), 32'(pv));
         if (s_plot && q_x.size() == stall_at && stalled < stall_len) begin
            t_pix_ready = 1'b0;
            stalled++;
         end else begin
            t_pix_ready = 1'b1;
         end
         if (s_plot && t_pix_ready) begin
            q_x.push_back(s_x); q_y.push_back(s_y); q_c.push_back(s_c);
         end
         pp = s_plot;
         ppr = t_pix_ready;
         pv = {s_x, s_y, s_c};
         if (s_done) begin
            done_at = i;
            err_seen = s_err;
            break;
         end
         @(posedge clk); #1;
      end
      t_start = 1'b0;
      t_pix_ready = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_done", 32'(s_ready), 32'd1);
   endtask

   initial begin
      int   d;
      logic e;
      int   cnt;
      int   guard;
      logic seen_done;
      logic [6:0] rc;
      logic [4:0] rcol;
      logic [2:0] rrow;
      int   sa, sl, exp_done;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready0", 32'(bus0.ready), 32'd1);
      chk("rst_ready1", 32'(bus1.ready), 32'd1);
      chk("rst_outs0", 32'({bus0.done, bus0.err, bus0.plot, bus0.x, bus0.y, bus0.colour, gc0}), 32'd0);
      chk("rst_outs1", 32'({bus1.done, bus1.err, bus1.plot, bus1.x, bus1.y, bus1.colour, gc1}), 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      run_req(1'b0, 7'd73, 5'd0, 3'd0, -1, 0, -1, d, e);
      chk("I_done_at", 32'(d), 32'd130);
      chk("I_err", 32'(e), 32'd0);
      chk("I_gcode", 32'(s_gc), 32'd73);
      chk("I_row0_bg", 32'(q_c[0] | q_c[7]), 32'd0);
      chk("I_fg_2_1", 32'(q_c[10]), 32'd7);
      chk("I_fg_3_2", 32'(q_c[19]), 32'd7);
      model(1'b0, 7'd73, 0, 0);
      compare_pixels("I");

      run_req(1'b0, 7'd46, 5'd2, 3'd1, -1, 0, -1, d, e);
      chk("dot_done_at", 32'(d), 32'd130);
      model(1'b0, 7'd46, 2, 1);
      compare_pixels("dot");

      run_req(1'b0, 7'd65, 5'd4, 3'd3, 5, 3, -1, d, e);
      chk("A_stall_done_at", 32'(d), 32'd133);
      model(1'b0, 7'd65, 4, 3);
      compare_pixels("A_stall");

      run_req(1'b1, 7'd32, 5'd1, 3'd1, -1, 0, -1, d, e);
      chk("tr_space_done_at", 32'(d), 32'd130);
      chk("tr_space_count", 32'(q_x.size()), 32'd0);
      run_req(1'b1, 7'd73, 5'd5, 3'd2, -1, 0, -1, d, e);
      chk("tr_I_done_at", 32'(d), 32'd130);
      model(1'b1, 7'd73, 5, 2);
      compare_pixels("tr_I");

      run_req(1'b0, 7'd65, 5'd20, 3'd0, -1, 0, -1, d, e);
      chk("oor_done_at", 32'(d), 32'd2);
      chk("oor_err", 32'(e), 32'd1);
      chk("oor_count", 32'(q_x.size()), 32'd0);

      run_req(1'b0, 7'd66, 5'd19, 3'd6, -1, 0, 50, d, e);
      chk("pulse_done_at", 32'(d), 32'd130);
      model(1'b0, 7'd66, 19, 6);
      compare_pixels("pulse");
      seen_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (!s_ready || s_done || s_plot) seen_done = 1'b1;
         @(posedge clk); #1;
      end
      chk("pulse_ignored", 32'(seen_done), 32'd0);

      for (int k = 0; k < 6; k++) begin
         rc   = 7'($urandom_range(33, 126));
         rcol = 5'($urandom_range(0, 21));
         rrow = 3'($urandom_range(0, 7));
         sa   = $urandom_range(0, 127);
         sl   = $urandom_range(0, 3);
         run_req(1'b0, rc, rcol, rrow, sa, sl, -1, d, e);
         exp_done = (rcol >= 20 || rrow >= 7) ? 2 : 130 + sl;
         chk("rnd_done_at", 32'(d), 32'(exp_done));
         chk("rnd_err", 32'(e), 32'(rcol >= 20 || rrow >= 7));
         model(1'b0, rc, int'(rcol), int'(rrow));
         compare_pixels("rnd");
      end

      sel = 1'b0;
      t_code = 7'd65; t_col = 5'd1; t_row = 3'd1;
      t_start = 1'b1;
      @(posedge clk); #1;
      t_start = 1'b0;
      cnt = 0;
      guard = 0;
      while (cnt < 40 && guard < 300) begin
         if (s_plot && t_pix_ready) cnt++;
         @(posedge clk); #1;
         guard++;
      end
      chk("abort_reached_40", 32'(cnt), 32'd40);
      resetn = 1'b0;
      #1;
      chk("abort_plot", 32'(s_plot), 32'd0);
      chk("abort_ready", 32'(s_ready), 32'd1);
      chk("abort_cleared", 32'({s_gc, s_x, s_y, s_c}), 32'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (s_done) seen_done = 1'b1;
      end
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (s_done) seen_done = 1'b1;
      end
      chk("abort_no_done", 32'(seen_done), 32'd0);

      run_req(1'b0, 7'd48, 5'd3, 3'd2, -1, 0, -1, d, e);
      chk("zero_done_at", 32'(d), 32'd130);
      chk("zero_err", 32'(e), 32'd0);
      model(1'b0, 7'd48, 3, 2);
      compare_pixels("zero");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
